shift_sequencer: RTL and testbench

Control stage that sits upstream of the 8-bit mux/register/shifter datapath and drives its select, load and shift-function inputs. On a start request it loads a seed value into the register through the mux. It then runs a programmed number of shift steps, each paced by a prescaled tick, feeding the shifter output back through the mux. It reports busy/done and the remaining step count for display.

---
 rtl/shift_sequencer.sv | 82 ++++++++
 tb/tb_shift_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: Moore sequencer that loads a seed then runs tick-paced shift steps; SHIFT_SEQ_LOOP_EN makes steps==0 run until stop
module shift_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  output logic              mux_sel,
  output logic              reg_load,
  output logic [1:0]        shift_func,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] remaining
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic dir_q, dir_d, loop_q, loop_d;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    presc_d = presc_q;
    dir_d = dir_q;
    loop_d = loop_q;
    if (stop) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        dir_d = dir;
        rem_d = steps;
`ifdef SHIFT_SEQ_LOOP_EN
        loop_d = steps == '0;
`else
        loop_d = 1'b0;
`endif
      end
      LOAD: begin
        state_d = (rem_q == '0 && !loop_q) ? DONE : WAIT;
        presc_d = '0;
      end
      WAIT: if (!pause) begin
        state_d = presc_q == TOP ? SHIFT : WAIT;
        presc_d = presc_q == TOP ? '0 : presc_q + 1'b1;
      end
      SHIFT: begin
        state_d = (loop_q || rem_q != STEP_W'(1)) ? WAIT : DONE;
        rem_d = rem_q == '0 ? rem_q : rem_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      rem_q <= '0;
      presc_q <= '0;
      dir_q <= 1'b0;
      loop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      presc_q <= presc_d;
      dir_q <= dir_d;
      loop_q <= loop_d;
    end
  end
  assign mux_sel = state_q == WAIT || state_q == SHIFT;
  assign reg_load = state_q == LOAD || state_q == SHIFT;
  assign shift_func = state_q == SHIFT ? (dir_q ? 2'd2 : 2'd1) : 2'd0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign remaining = rem_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench checking cycle-exact load/shift/done events of shift_sequencer
module tb_shift_sequencer;
  logic clk = 1'b0, clear = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0;
  logic [3:0] steps = '0;
  logic mux_sel, reg_load, busy, done;
  logic [1:0] shift_func;
  logic [3:0] remaining;
  int cyc = 0, checks = 0, errors = 0, t0;
  typedef struct packed {
    int cyc;
    logic load;
    logic mux;
    logic [1:0] func;
    logic done;
    logic [3:0] rem;
  } ev_t;
  ev_t q[$];
  shift_sequencer dut (
    .clk(clk), .clear(clear), .start(start), .stop(stop), .pause(pause), .dir(dir),
    .steps(steps), .mux_sel(mux_sel), .reg_load(reg_load), .shift_func(shift_func),
    .busy(busy), .done(done), .remaining(remaining)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    ev_t a, e;
    if (!clear && (reg_load || done)) begin
      a = '{cyc, reg_load, mux_sel, shift_func, done, remaining};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d load=%b mux=%b func=%0d done=%b rem=%0d, expected none", a.cyc, a.load, a.mux, a.func, a.done, a.rem);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL event: got cyc=%0d load=%b mux=%b func=%0d done=%b rem=%0d, expected cyc=%0d load=%b mux=%b func=%0d done=%b rem=%0d",
            a.cyc, a.load, a.mux, a.func, a.done, a.rem, e.cyc, e.load, e.mux, e.func, e.done, e.rem);
        end
      end
    end
  end
  function automatic void ex(int c, logic l, logic m, logic [1:0] f, logic d, logic [3:0] r);
    q.push_back('{c, l, m, f, d, r});
  endfunction
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic go(logic [3:0] s, logic d);
    steps = s;
    dir = d;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
  endtask
  task automatic outs_zero(string n);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_mux"}, int'(mux_sel), 0);
    chk({n, "_load"}, int'(reg_load), 0);
    chk({n, "_func"}, int'(shift_func), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_rem"}, int'(remaining), 0);
  endtask
  initial begin
    run(2);
    outs_zero("reset");
    clear = 1'b0;
    run(2);
    // clear asserted in the middle of a WAIT
    ex(cyc + 1, 1, 0, 0, 0, 5);
    go(5, 0);
    run(2);
    clear = 1'b1;
    #1;
    outs_zero("clear_mid");
    step();
    clear = 1'b0;
    run(8);
    chk("after_clear_busy", int'(busy), 0);
    chk("after_clear_drain", q.size(), 0);
    // basic left run
    ex(cyc + 1, 1, 0, 0, 0, 3);
    ex(cyc + 6, 1, 1, 1, 0, 3);
    ex(cyc + 11, 1, 1, 1, 0, 2);
    ex(cyc + 16, 1, 1, 1, 0, 1);
    ex(cyc + 17, 0, 0, 0, 1, 0);
    go(3, 0);
    run(6);
    chk("left_rem_after_shift1", int'(remaining), 2);
    chk("left_mux_wait", int'(mux_sel), 1);
    run(11);
    chk("left_end_busy", int'(busy), 0);
    chk("left_end_rem", int'(remaining), 0);
    chk("left_drain", q.size(), 0);
    // right run, first WAIT paused for 3 cycles
    ex(cyc + 1, 1, 0, 0, 0, 2);
    ex(cyc + 9, 1, 1, 2, 0, 2);
    ex(cyc + 14, 1, 1, 2, 0, 1);
    ex(cyc + 15, 0, 0, 0, 1, 0);
    go(2, 1);
    step();
    pause = 1'b1;
    run(3);
    pause = 1'b0;
    run(11);
    chk("right_end_busy", int'(busy), 0);
    chk("right_drain", q.size(), 0);
    // abort the cycle after the first SHIFT
    ex(cyc + 1, 1, 0, 0, 0, 4);
    ex(cyc + 6, 1, 1, 1, 0, 4);
    go(4, 0);
    run(6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rem", int'(remaining), 3);
    run(10);
    chk("abort_drain", q.size(), 0);
    // stop beats start in the same cycle
    stop = 1'b1;
    go(7, 0);
    stop = 1'b0;
    chk("stop_start_busy", int'(busy), 0);
    chk("stop_start_rem", int'(remaining), 3);
    run(3);
    chk("stop_start_drain", q.size(), 0);
    // zero steps
    ex(cyc + 1, 1, 0, 0, 0, 0);
`ifdef SHIFT_SEQ_LOOP_EN
    ex(cyc + 6, 1, 1, 1, 0, 0);
    ex(cyc + 11, 1, 1, 1, 0, 0);
    ex(cyc + 16, 1, 1, 1, 0, 0);
    go(0, 0);
    run(16);
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(3);
`else
    ex(cyc + 2, 0, 0, 0, 1, 0);
    go(0, 0);
    run(3);
`endif
    chk("zero_busy", int'(busy), 0);
    chk("zero_drain", q.size(), 0);
    // start while busy is ignored
    ex(cyc + 1, 1, 0, 0, 0, 2);
    ex(cyc + 6, 1, 1, 1, 0, 2);
    ex(cyc + 11, 1, 1, 1, 0, 1);
    ex(cyc + 12, 0, 0, 0, 1, 0);
    go(2, 0);
    run(2);
    steps = 4'd9;
    dir = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ignore_rem", int'(remaining), 2);
    run(9);
    chk("ignore_busy", int'(busy), 0);
    chk("ignore_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
